// File: rtl/signal_meter_pkg.sv
// signal_meter shared definitions:
// FSM encoding, register map, status layout.
package signal_meter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2,
    LOW       = 2'd3
  } state_t;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_PER_LO  = 3'd1;
  localparam logic [2:0] ADDR_PER_HI  = 3'd2;
  localparam logic [2:0] ADDR_HIGH_LO = 3'd3;
  localparam logic [2:0] ADDR_HIGH_HI = 3'd4;
  localparam logic [2:0] ADDR_MEAS    = 3'd5;
  localparam logic [2:0] ADDR_ID      = 3'd6;
  localparam logic [2:0] ADDR_ZERO    = 3'd7;

  localparam logic [7:0] ID_DEFAULT = 8'hA5;

  localparam int ST_OVF   = 7;
  localparam int ST_VALID = 6;
  localparam int ST_BUSY  = 5;
  localparam int ST_CONT  = 4;

endpackage

// File: rtl/signal_meter_if.sv
// signal_meter register read port:
// strobe + address in, registered data out.
interface signal_meter_if;

  logic       read_strobe;
  logic [2:0] address;
  logic [7:0] read_data;

  modport master (
    output read_strobe,
    output address,
    input  read_data
  );

  modport slave (
    input  read_strobe,
    input  address,
    output read_data
  );

endinterface

// File: rtl/signal_meter_edge_sync.sv
// edge_sync: multi-flop synchroniser with
// one extra stage for rise/fall strobes.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;
  logic                   level;

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

  // shift the pin through the chain, keep last level
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= level;
    end
  end

endmodule

// File: rtl/signal_meter.sv
// signal_meter: period / high-time meter
// with shadowed 8-bit register read port.
module signal_meter
  import signal_meter_pkg::*;
#(
  parameter int         CNT_W       = 16,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_VALUE    = ID_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           signal_in,
  input  logic           arm,
  input  logic           continuous,
  signal_meter_if.slave  bus,
  output logic           busy,
  output logic           valid,
  output logic           overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [CNT_W-1:0] period_q, period_n;
  logic [CNT_W-1:0] high_q, high_n;
  logic             valid_n, ovf_n;
  logic [7:0]       meas, meas_n;
  logic [7:0]       per_sh, high_sh;
  logic [7:0]       rdata, status;
  logic [15:0]      per16, high16;
  logic             rise, fall;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .din (signal_in),
    .rise(rise),
    .fall(fall)
  );

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  assign busy    = (state != IDLE);
  assign per16   = 16'(period_q);
  assign high16  = 16'(high_q);
  assign bus.read_data = rdata;

  // next state, counter and result updates
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    period_n = period_q;
    high_n   = high_q;
    valid_n  = valid;
    ovf_n    = overflow;
    meas_n   = meas;
    if (arm) begin
      valid_n = 1'b0;
      ovf_n   = 1'b0;
      cnt_n   = '0;
      state_n = WAIT_RISE;
    end else begin
      unique case (state)
        IDLE: ;
        WAIT_RISE: begin
          if (rise) begin
            cnt_n   = CNT_ONE;
            state_n = HIGH;
          end
        end
        HIGH: begin
          if (fall) begin
            high_n  = cnt;
            cnt_n   = cnt_inc;
            state_n = LOW;
          end else if (cnt == CNT_MAX) begin
            ovf_n   = 1'b1;
            state_n = continuous ? WAIT_RISE : IDLE;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        LOW: begin
          if (rise) begin
            period_n = cnt;
            valid_n  = 1'b1;
            meas_n   = meas + 8'd1;
            if (continuous) begin
              cnt_n   = CNT_ONE;
              state_n = HIGH;
            end else begin
              state_n = IDLE;
            end
          end else if (cnt == CNT_MAX) begin
            ovf_n   = 1'b1;
            state_n = continuous ? WAIT_RISE : IDLE;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      endcase
    end
  end

  // measurement state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
      meas     <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      period_q <= period_n;
      high_q   <= high_n;
      valid    <= valid_n;
      overflow <= ovf_n;
      meas     <= meas_n;
    end
  end

  // status byte assembly
  always_comb begin
    status           = '0;
    status[ST_OVF]   = overflow;
    status[ST_VALID] = valid;
    status[ST_BUSY]  = busy;
    status[ST_CONT]  = continuous;
    status[1:0]      = state;
  end

  // registered reads; low-byte reads latch the high byte
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata   <= '0;
      per_sh  <= '0;
      high_sh <= '0;
    end else if (bus.read_strobe) begin
      unique case (bus.address)
        ADDR_STATUS:  rdata <= status;
        ADDR_PER_LO: begin
          rdata  <= per16[7:0];
          per_sh <= per16[15:8];
        end
        ADDR_PER_HI:  rdata <= per_sh;
        ADDR_HIGH_LO: begin
          rdata   <= high16[7:0];
          high_sh <= high16[15:8];
        end
        ADDR_HIGH_HI: rdata <= high_sh;
        ADDR_MEAS:    rdata <= meas;
        ADDR_ID:      rdata <= ID_VALUE;
        ADDR_ZERO:    rdata <= 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_signal_meter.sv
// tb_signal_meter: timestamp model of the meter
// checked every cycle, plus directed literals.
module tb_signal_meter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arm = 1'b0;
  logic       cont = 1'b0;
  logic       rs = 1'b0;
  logic [2:0] addr = 3'd0;
  logic       pin_man = 1'b0;
  logic       wave_pin = 1'b0;
  logic       wave_on = 1'b0;
  logic       sig;
  int         hi_n = 3;
  int         lo_n = 5;
  int         n_cmp = 0;
  int         n_bad = 0;

  logic busy16, valid16, ovf16;
  logic busy9, valid9, ovf9;

  assign sig = wave_on ? wave_pin : pin_man;

  always #5 clk = ~clk;

  signal_meter_if bus16();
  signal_meter_if bus9();

  assign bus16.read_strobe = rs;
  assign bus16.address     = addr;
  assign bus9.read_strobe  = rs;
  assign bus9.address      = addr;

  signal_meter #(
    .CNT_W(16), .SYNC_STAGES(2), .ID_VALUE(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .signal_in(sig),
    .arm(arm), .continuous(cont), .bus(bus16),
    .busy(busy16), .valid(valid16),
    .overflow(ovf16)
  );

  signal_meter #(
    .CNT_W(9), .SYNC_STAGES(2), .ID_VALUE(8'hA5)
  ) dut9 (
    .clk(clk), .rst(rst), .signal_in(sig),
    .arm(arm), .continuous(cont), .bus(bus9),
    .busy(busy9), .valid(valid9),
    .overflow(ovf9)
  );

  // model: ph 0 idle, 1 waiting, 2 high, 3 low;
  // t0 = timestamp of the rise opening a measurement
  typedef struct {
    int         ph;
    int         t0;
    logic [15:0] per;
    logic [15:0] hi;
    logic [7:0] mc;
    logic [7:0] psh;
    logic [7:0] hsh;
    logic [7:0] rd;
    bit         val;
    bit         ovf;
  } mdl_t;

  function automatic mdl_t step(
    mdl_t m, bit r, bit a, bit c, bit s,
    logic [2:0] ad, bit ri, bit fa,
    int t, int mx);
    int e;
    if (r) begin
      m = '{default: 0};
      return m;
    end
    if (s) begin
      case (ad)
        3'd0: m.rd = {m.ovf, m.val, m.ph != 0, c,
                      2'b00, 2'(m.ph)};
        3'd1: begin
          m.rd  = m.per[7:0];
          m.psh = m.per[15:8];
        end
        3'd2: m.rd = m.psh;
        3'd3: begin
          m.rd  = m.hi[7:0];
          m.hsh = m.hi[15:8];
        end
        3'd4: m.rd = m.hsh;
        3'd5: m.rd = m.mc;
        3'd6: m.rd = 8'hA5;
        default: m.rd = 8'h00;
      endcase
    end
    e = t - m.t0;
    if (a) begin
      m.val = 1'b0;
      m.ovf = 1'b0;
      m.ph  = 1;
    end else begin
      case (m.ph)
        1: if (ri) begin
          m.t0 = t;
          m.ph = 2;
        end
        2: if (fa) begin
          m.hi = 16'(e);
          m.ph = 3;
        end else if (e >= mx) begin
          m.ovf = 1'b1;
          m.ph  = c ? 1 : 0;
        end
        3: if (ri) begin
          m.per = 16'((e > mx) ? mx : e);
          m.val = 1'b1;
          m.mc  = m.mc + 8'd1;
          if (c) begin
            m.t0 = t;
            m.ph = 2;
          end else begin
            m.ph = 0;
          end
        end else if (e >= mx) begin
          m.ovf = 1'b1;
          m.ph  = c ? 1 : 0;
        end
        default: ;
      endcase
    end
    return m;
  endfunction

  logic [2:0] h = 3'b000;
  int         tcyc = 0;
  bit         chk_en = 1'b0;
  mdl_t       m16;
  mdl_t       m9;

  // advance both models on every clock edge
  always @(posedge clk) begin
    bit ri;
    bit fa;
    ri = h[1] & ~h[2];
    fa = ~h[1] & h[2];
    m16 = step(m16, rst, arm, cont, rs, addr,
               ri, fa, tcyc, 65535);
    m9  = step(m9, rst, arm, cont, rs, addr,
               ri, fa, tcyc, 511);
    h = rst ? 3'b000 : {h[1:0], sig};
    tcyc++;
    if (rst) chk_en = 1'b1;
  end

  task automatic chk(string nm,
                     logic [7:0] act,
                     logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd16", bus16.read_data, m16.rd);
      chk("busy16", 8'(busy16), 8'(m16.ph != 0));
      chk("valid16", 8'(valid16), 8'(m16.val));
      chk("ovf16", 8'(ovf16), 8'(m16.ovf));
      chk("rd9", bus9.read_data, m9.rd);
      chk("busy9", 8'(busy9), 8'(m9.ph != 0));
      chk("valid9", 8'(valid9), 8'(m9.val));
      chk("ovf9", 8'(ovf9), 8'(m9.ovf));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(logic [2:0] a, int e16,
                    int e9, string nm);
    addr = a;
    rs   = 1'b1;
    tick();
    rs   = 1'b0;
    if (e16 >= 0)
      chk(nm, bus16.read_data, 8'(e16));
    if (e9 >= 0)
      chk({nm, "_9"}, bus9.read_data, 8'(e9));
  endtask

  // free-running square wave source
  initial begin
    forever begin
      if (wave_on) begin
        wave_pin = 1'b1;
        repeat (hi_n) tick();
        wave_pin = 1'b0;
        repeat (lo_n) tick();
      end else begin
        tick();
      end
    end
  end

  initial begin
    int v;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    rd(3'd6, 'hA5, 'hA5, "id");
    rd(3'd0, 'h00, 'h00, "status_rst");

    hi_n = 3;
    lo_n = 5;
    wave_on = 1'b1;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (40) tick();
    rd(3'd3, 3, 3, "t2_high");
    rd(3'd4, 0, 0, "t2_high_hi");
    rd(3'd1, 8, 8, "t2_per");
    rd(3'd2, 0, 0, "t2_per_hi");
    rd(3'd5, 1, 1, "t2_meas");
    rd(3'd0, 'h40, 'h40, "t2_status");
    chk("t2_valid", 8'(valid16), 8'd1);
    chk("t2_busy", 8'(busy16), 8'd0);

    cont = 1'b1;
    hi_n = 300;
    lo_n = 700;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (3000) tick();
    rd(3'd1, 'hE8, -1, "t3_per_lo");
    rd(3'd2, 'h03, -1, "t3_per_hi");
    rd(3'd3, 'h2C, -1, "t3_high_lo");
    rd(3'd4, 'h01, -1, "t3_high_hi");
    rd(3'd5, -1, -1, "t3_meas_a");
    v = int'(m16.rd);
    repeat (999) tick();
    rd(3'd5, (v + 1) & 255, -1, "t3_meas_step");

    hi_n = 100;
    lo_n = 155;
    repeat (1500) tick();
    rd(3'd1, 'hFF, 'hFF, "t4_per_255");
    lo_n = 156;
    repeat (800) tick();
    rd(3'd2, 'h00, 'h00, "t4_shadow_old");
    rd(3'd1, 'h00, 'h00, "t4_per_256_lo");
    rd(3'd2, 'h01, 'h01, "t4_per_256_hi");

    wave_on = 1'b0;
    cont = 1'b0;
    pin_man = 1'b1;
    repeat (10) tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (600) tick();
    rd(3'd0, 'h21, 'h21, "t5_const_wait");

    pin_man = 1'b0;
    repeat (5) tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (3) tick();
    pin_man = 1'b1;
    repeat (600) tick();
    rd(3'd0, 'h22, 'h80, "t5_ovf_status");
    chk("t5_ovf9", 8'(ovf9), 8'd1);
    chk("t5_valid9", 8'(valid9), 8'd0);
    chk("t5_ovf16", 8'(ovf16), 8'd0);

    pin_man = 1'b0;
    repeat (4) tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    pin_man = 1'b1;
    repeat (3) tick();
    pin_man = 1'b0;
    repeat (5) tick();
    pin_man = 1'b1;
    tick();
    tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("t6_valid", 8'(valid16), 8'd0);
    rd(3'd0, 'h21, 'h21, "t6_status");
    rd(3'd1, 'h00, 'h00, "t6_per_lo");
    rd(3'd2, 'h01, 'h01, "t6_per_hi");
    rd(3'd3, 'h03, 'h03, "t6_high");

    rd(3'd6, 'hA5, 'hA5, "pre_rst_id");
    pin_man = 1'b0;
    repeat (4) tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    pin_man = 1'b1;
    repeat (5) tick();
    chk("pre_rst_busy", 8'(busy16), 8'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_rd", bus16.read_data, 8'h00);
    chk("rst_busy", 8'(busy16), 8'd0);
    chk("rst_valid", 8'(valid16), 8'd0);
    chk("rst_ovf", 8'(ovf16), 8'd0);
    chk("rst_rd9", bus9.read_data, 8'h00);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
